// File: rtl/jpeg_ycc_block_front.sv
// ============================================================================
// Module   : jpeg_ycc_block_front
// Brief    : 2-stage RGB->YCbCr (JFIF, 8-bit fixed point) plus Y block collector.
//            Optional macro YCC_ROUND_EN: round-half-up instead of floor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeg_ycc_block_front #(
  parameter int BLOCK_PIX = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          input_1pix_enable,
  input  logic [7:0]                    Red,
  input  logic [7:0]                    Green,
  input  logic [7:0]                    Blue,
  input  logic                          input_enable,
  output logic [23:0]                   ycc_out,
  output logic                          ycc_valid,
  output logic [8*BLOCK_PIX-1:0]        pix_data,
  output logic                          block_valid,
  output logic [$clog2(BLOCK_PIX)-1:0]  pix_count
);

  localparam int c_cnt_w = $clog2(BLOCK_PIX);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLOCK_PIX - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
  localparam logic signed [17:0] c_off  = 18'sd128;
`ifdef YCC_ROUND_EN
  localparam logic signed [17:0] c_rnd  = 18'sd128;
`else
  localparam logic signed [17:0] c_rnd  = 18'sd0;
`endif

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 18'sd0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  logic signed [17:0] w_r, w_g, w_b;
  logic signed [17:0] w_sy, w_scb, w_scr;
  logic signed [17:0] r_sy, r_scb, r_scr;
  logic               r_v1;
  logic [23:0]        r_ycc;
  logic               r_v2;

  assign w_r = $signed({10'd0, Red});
  assign w_g = $signed({10'd0, Green});
  assign w_b = $signed({10'd0, Blue});

  assign w_sy  =  18'sd77  * w_r + 18'sd150 * w_g + 18'sd29  * w_b + c_rnd;
  assign w_scb = -18'sd43  * w_r - 18'sd85  * w_g + 18'sd128 * w_b + c_rnd;
  assign w_scr =  18'sd128 * w_r - 18'sd107 * w_g - 18'sd21  * w_b + c_rnd;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sy  <= '0;
      r_scb <= '0;
      r_scr <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= input_1pix_enable;
      if (input_1pix_enable) begin
        r_sy  <= w_sy;
        r_scb <= w_scb;
        r_scr <= w_scr;
      end
    end
  end

  // Output register only moves on valid data so ycc_out holds across bubbles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ycc <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1)
        r_ycc <= {clamp8(r_sy >>> 8),
                  clamp8((r_scb >>> 8) + c_off),
                  clamp8((r_scr >>> 8) + c_off)};
    end
  end

  assign ycc_out   = r_ycc;
  assign ycc_valid = r_v2;

  logic [8*BLOCK_PIX-1:0] r_buf;
  logic [8*BLOCK_PIX-1:0] w_buf_next;
  logic [8*BLOCK_PIX-1:0] r_pix_data;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     w_wr_idx;
  logic                   r_bv;

  // A restart redirects the concurrent sample to entry 0.
  assign w_wr_idx = input_enable ? '0 : r_cnt;

  always_comb begin
    w_buf_next = r_buf;
    if (r_v2)
      w_buf_next[{w_wr_idx, 3'b000} +: 8] = r_ycc[23:16];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_buf      <= '0;
      r_pix_data <= '0;
      r_cnt      <= '0;
      r_bv       <= 1'b0;
    end else begin
      r_buf <= w_buf_next;
      r_bv  <= 1'b0;
      if (input_enable) begin
        r_cnt <= r_v2 ? c_one : '0;
      end else if (r_v2) begin
        r_cnt <= r_cnt + c_one;
        if (r_cnt == c_last) begin
          r_pix_data <= w_buf_next;
          r_bv       <= 1'b1;
        end
      end
    end
  end

  assign pix_data    = r_pix_data;
  assign block_valid = r_bv;
  assign pix_count   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_ycc_block_front.sv
// ============================================================================
// Module   : tb_jpeg_ycc_block_front
// Brief    : Directed self-checking bench for jpeg_ycc_block_front.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jpeg_ycc_block_front;

  localparam int c_bp = 64;

  logic              clock;
  logic              reset_n;
  logic              input_1pix_enable;
  logic [7:0]        Red, Green, Blue;
  logic              input_enable;
  logic [23:0]       ycc_out;
  logic              ycc_valid;
  logic [8*c_bp-1:0] pix_data;
  logic              block_valid;
  logic [5:0]        pix_count;

  int n_vec = 0;
  int n_err = 0;

  jpeg_ycc_block_front #(.BLOCK_PIX(c_bp)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .input_1pix_enable (input_1pix_enable),
    .Red               (Red),
    .Green             (Green),
    .Blue              (Blue),
    .input_enable      (input_enable),
    .ycc_out           (ycc_out),
    .ycc_valid         (ycc_valid),
    .pix_data          (pix_data),
    .block_valid       (block_valid),
    .pix_count         (pix_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] exp_y(input int mode, input int val, input int i);
    if (mode == 0) return 8'(i);
    if (mode == 1) return 8'(val);
    return (i < c_bp) ? 8'd1 : 8'd2;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({ycc_out, ycc_valid, block_valid, pix_count} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ycc=%h v=%b bv=%b cnt=%0d want all 0",
               ycc_out, ycc_valid, block_valid, pix_count);
    end
    n_vec++;
    if (pix_data !== '0) begin
      n_err++;
      $display("FAIL reset_pix_data: got nonzero want 0");
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_colour_points();
    logic [23:0] pts [5];
    logic [23:0] exp [5];
    pts[0] = 24'hFFFFFF; exp[0] = {8'd255, 8'd128, 8'd128};
    pts[1] = 24'h000000; exp[1] = {8'd0,   8'd128, 8'd128};
`ifdef YCC_ROUND_EN
    pts[2] = 24'hFF0000; exp[2] = {8'd77,  8'd85,  8'd255};
    pts[3] = 24'h0000FF; exp[3] = {8'd29,  8'd255, 8'd107};
`else
    pts[2] = 24'hFF0000; exp[2] = {8'd76,  8'd85,  8'd255};
    pts[3] = 24'h0000FF; exp[3] = {8'd28,  8'd255, 8'd107};
`endif
    pts[4] = 24'h00FF00; exp[4] = {8'd149, 8'd43,  8'd21};
    for (int p = 0; p < 5; p++) begin
      {Red, Green, Blue} = pts[p];
      input_1pix_enable = 1'b1;
      tick();
      input_1pix_enable = 1'b0;
      tick();
      n_vec++;
      if (ycc_valid !== 1'b1 || ycc_out !== exp[p]) begin
        n_err++;
        $display("FAIL colour_%0d: got v=%b ycc=%h want v=1 ycc=%h", p, ycc_valid, ycc_out, exp[p]);
      end
      tick();
      n_vec++;
      if (ycc_valid !== 1'b0 || ycc_out !== exp[p]) begin
        n_err++;
        $display("FAIL colour_hold_%0d: got v=%b ycc=%h want v=0 ycc=%h", p, ycc_valid, ycc_out, exp[p]);
      end
    end
    n_vec++;
    if (pix_count !== 6'd5) begin
      n_err++;
      $display("FAIL colour_count: got %0d want 5", pix_count);
    end
  endtask

  task automatic do_restart();
    input_enable = 1'b1;
    tick();
    input_enable = 1'b0;
    n_vec++;
    if (pix_count !== 6'd0) begin
      n_err++;
      $display("FAIL restart_count: got %0d want 0", pix_count);
    end
  endtask

  // Streams npix grey pixels; checks every Y, pix_count, block timing and contents.
  task automatic run_stream(input string name, input int npix, input bit gapped,
                            input int mode, input int val);
    int sent = 0;
    int nv = 0;
    int nb = 0;
    int last64 = -10;
    int prev_pulse = -1;
    int ncyc;
    logic [7:0] y;
    logic [8*c_bp-1:0] exp_blk;
    ncyc = npix * (gapped ? 2 : 1) + 4;
    for (int t = 0; t < ncyc; t++) begin
      if (sent < npix && (!gapped || (t % 2) == 0)) begin
        y = exp_y(mode, val, sent);
        Red = y; Green = y; Blue = y;
        input_1pix_enable = 1'b1;
        sent++;
      end else begin
        input_1pix_enable = 1'b0;
      end
      tick();
      n_vec++;
      if (pix_count !== 6'(nv % c_bp)) begin
        n_err++;
        $display("FAIL %s_count t=%0d: got %0d want %0d", name, t, pix_count, nv % c_bp);
      end
      if (block_valid === 1'b1) begin
        n_vec++;
        if (t != last64 + 1) begin
          n_err++;
          $display("FAIL %s_pulse_time: got t=%0d want %0d", name, t, last64 + 1);
        end
        if (prev_pulse >= 0) begin
          n_vec++;
          if (t - prev_pulse != c_bp) begin
            n_err++;
            $display("FAIL %s_pulse_gap: got %0d want %0d", name, t - prev_pulse, c_bp);
          end
        end
        for (int j = 0; j < c_bp; j++)
          exp_blk[j*8 +: 8] = exp_y(mode, val, nb * c_bp + j);
        n_vec++;
        if (pix_data !== exp_blk) begin
          n_err++;
          $display("FAIL %s_block_%0d: got %h want %h", name, nb, pix_data[63:0], exp_blk[63:0]);
        end
        prev_pulse = t;
        nb++;
      end
      if (ycc_valid === 1'b1) begin
        n_vec++;
        if (ycc_out !== {exp_y(mode, val, nv), 8'd128, 8'd128}) begin
          n_err++;
          $display("FAIL %s_ycc_%0d: got %h want %h", name, nv, ycc_out,
                   {exp_y(mode, val, nv), 8'd128, 8'd128});
        end
        nv++;
        if (nv % c_bp == 0) last64 = t;
      end
    end
    input_1pix_enable = 1'b0;
    n_vec++;
    if (nv != npix || nb != npix / c_bp || pix_count !== 6'(npix % c_bp)) begin
      n_err++;
      $display("FAIL %s_totals: got valid=%0d blocks=%0d cnt=%0d want %0d %0d %0d",
               name, nv, nb, pix_count, npix, npix / c_bp, npix % c_bp);
    end
  endtask

  task automatic test_restart();
    run_stream("pre_restart", 10, 1'b0, 1, 200);
    do_restart();
    run_stream("restart", 64, 1'b0, 1, 7);
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < 30; i++) begin
      Red = 8'd9; Green = 8'd9; Blue = 8'd9;
      input_1pix_enable = 1'b1;
      tick();
    end
    input_1pix_enable = 1'b0;
    reset_n = 1'b0;
    tick();
    n_vec++;
    if ({ycc_out, ycc_valid, block_valid, pix_count} !== 32'd0 || pix_data !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got ycc=%h v=%b bv=%b cnt=%0d want all 0",
               ycc_out, ycc_valid, block_valid, pix_count);
    end
    reset_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (ycc_valid !== 1'b0 || pix_count !== 6'd0) begin
      n_err++;
      $display("FAIL midreset_flush: got v=%b cnt=%0d want v=0 cnt=0", ycc_valid, pix_count);
    end
    run_stream("post_reset", 64, 1'b0, 1, 5);
  endtask

  initial begin
    reset_n           = 1'b0;
    input_1pix_enable = 1'b0;
    input_enable      = 1'b0;
    Red   = '0;
    Green = '0;
    Blue  = '0;
    test_reset();
    test_colour_points();
    do_restart();
    run_stream("stream", 64, 1'b0, 0, 0);
    run_stream("gapped", 64, 1'b1, 0, 0);
    test_restart();
    test_reset_mid_block();
    run_stream("back_to_back", 128, 1'b0, 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
